ct_sequencer: RTL and testbench
===============================

Name: ct_sequencer

Overview:
- Parametrised CT (calibration-tone) sequencer and TV/TH polarisation controller.
- It drives DDS2 OSK gating, the TR/LO switches and RX channel power overrides around a CT window.
- Sits between the AD9914 control logic and the RF front-end switch outputs.
- Successor to the single-shot CT flow:
  - all strobes are synchronised and edge-detected in the clk domain;
  - arm timeout;
  - status outputs;
  - extra TV modes;
  - parametrised widths and channel count.

Parameters:
- CNT_W, 32, width of ct_period and the window counter.
- RX_CH, 3, number of RX channel power-control lines.
- ARM_TO, 1000000, clk cycles allowed in ARMED before a timeout; 0 disables the timeout.
- RX_CT_VAL, {RX_CH{1'b0}}, value forced onto rx_ch_ctrl while CT is active.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ct_period  in  CNT_W  CT window length minus one, in clk cycles.
- tv_mode  in  2  TV/TH mode select.
- ad9914_update_2  in  1  async strobe; rising edge arms CT.
- ad9914_trig_1  in  1  async strobe; rising edge toggles TV in mode 11.
- ad9914_trig_2  in  1  async strobe; rising edge starts the CT window.
- ad9914_osk_temp  in  1  raw OSK from DDS2 control.
- rx_ch_pwr_ctrl  in  RX_CH  normal RX power control.
- ad9914_osk_2  out  1  gated OSK.
- tr  out  1  TR switch.
- lo  out  1  LO switch.
- tv  out  1  polarisation select.
- rx_ch_ctrl  out  RX_CH  RX power control to the front end.
- ct_busy  out  1  high in ARMED and RUN.
- ct_done  out  1  one-cycle pulse at window end.
- ct_timeout  out  1  one-cycle pulse on arm timeout.

Behaviour:
- Input conditioning:
  - Each async strobe passes through a 2-FF synchroniser, then a rising-edge detector.
  - This gives a 3-cycle latency from input edge to the internal one-cycle pulse (upd_p, t1_p, t2_p).
  - ad9914_osk_temp is not synchronised; it is ANDed combinationally.
- Reset values:
  - All FSM state, counters and synchronisers are 0.
  - state = IDLE, ct_enable = 0, tv = 1, ct_done = 0, ct_timeout = 0.
- Outputs:
  - ad9914_osk_2 = ct_enable & ad9914_osk_temp.
  - tr = lo = ct_enable.
  - rx_ch_ctrl = ct_enable ? RX_CT_VAL : rx_ch_pwr_ctrl.
  - ct_busy = ct_enable.
  - ct_enable is a register.
- FSM states IDLE, ARMED, RUN, DONE:
  - IDLE:
    - upd_p -> ARMED; latch ct_period into period_reg; clear arm_cnt; ct_enable <= 1.
    - t2_p in IDLE is ignored.
  - ARMED:
    - t2_p -> RUN with cnt <= 0.
    - upd_p (without t2_p) re-latches period_reg and restarts arm_cnt.
    - If t2_p and upd_p coincide, t2_p wins and period_reg is not re-latched.
    - If ARM_TO != 0 and arm_cnt == ARM_TO-1 -> IDLE; ct_enable <= 0; ct_timeout pulses 1 cycle.
  - RUN:
    - cnt increments each cycle; when cnt == period_reg -> DONE.
    - The window is exactly period_reg+1 cycles; period 0 gives 1 cycle.
    - upd_p and t2_p are ignored in RUN.
  - DONE:
    - ct_enable <= 0; ct_done pulses 1 cycle; -> IDLE.
- Counter width:
  - cnt and arm_cnt are CNT_W bits and never wrap.
  - period_reg = all-ones is legal (2^CNT_W cycles).
- TV, registered:
  - mode 00: tv <= 0.
  - mode 01: tv <= 1.
  - mode 11: tv toggles on t1_p.
  - mode 10: tv toggles on each ct_done.
  - A mode change takes effect on the next clk; the toggle modes start from the current tv value.
- rst asserted mid-operation:
  - next clk returns the FSM to IDLE and tv to 1;
  - outputs drop to their non-CT values one cycle after rst is sampled.

Optional Feature:
- CT_REPEAT_EN defined:
  - adds input ct_repeat [7:0], latched with period_reg on entry to ARMED;
  - DONE decrements a repeat counter; if it is non-zero, return to ARMED, keep ct_enable = 1 and restart arm_cnt;
  - ct_done pulses on every window;
  - ct_repeat = 0 behaves as single-shot.
- Undefined: port absent, single-shot only.

Test Plan:
- rst, then ct_period = 5, update pulse, trig_2 pulse -> ct_busy high 3 clk after update; tr/lo high; rx_ch_ctrl = 000; window exactly 6 clk after internal t2_p; ct_done one pulse; outputs return to rx_ch_pwr_ctrl = 101.
- ct_period = 0 -> RUN lasts 1 clk; ct_done fires the following clk.
- ARM_TO = 16, update with no trig_2 -> ct_timeout pulses after 16 clk in ARMED; ct_busy falls; a later trig_2 has no effect.
- Update + trig_2 in the same internal cycle while ARMED (period 3 then 9) -> RUN uses period 3; update during RUN is ignored.
- tv_mode = 11 with 4 trig_1 edges -> tv 1,0,1,0,1; switch to 10 and run 2 CTs -> tv toggles at each ct_done; mode 00 -> tv = 0 next clk.
- Assert rst mid-RUN at cnt = 2 -> state IDLE, ct_busy = 0, tv = 1, no ct_done pulse.

Source files
------------

// File: rtl/ct_sequencer.sv
// ct_sequencer: calibration-tone window sequencer and TV/TH polarisation controller.
// Gates DDS2 OSK, drives the TR/LO switches and overrides RX channel power around a CT window.
// Optional feature macro: CT_REPEAT_EN (adds ct_repeat input for back-to-back windows).
module ct_sequencer #(
    parameter int unsigned       CNT_W     = 32,
    parameter int unsigned       RX_CH     = 3,
    parameter int unsigned       ARM_TO    = 1000000,
    parameter logic [RX_CH-1:0]  RX_CT_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] ct_period,
    input  logic [1:0]       tv_mode,
    input  logic             ad9914_update_2,
    input  logic             ad9914_trig_1,
    input  logic             ad9914_trig_2,
    input  logic             ad9914_osk_temp,
    input  logic [RX_CH-1:0] rx_ch_pwr_ctrl,
`ifdef CT_REPEAT_EN
    input  logic [7:0]       ct_repeat,
`endif
    output logic             ad9914_osk_2,
    output logic             tr,
    output logic             lo,
    output logic             tv,
    output logic [RX_CH-1:0] rx_ch_ctrl,
    output logic             ct_busy,
    output logic             ct_done,
    output logic             ct_timeout
);

    typedef enum logic [1:0] {StIdle, StArmed, StRun, StDone} state_e;

    // Last arm_cnt value before timeout; only meaningful when ARM_TO != 0.
    localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(ARM_TO - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state;
    logic             ct_enable;
    logic [CNT_W-1:0] period_reg;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] arm_cnt;
`ifdef CT_REPEAT_EN
    logic [7:0]       rep_cnt;
`endif

    // [0],[1] form the 2-FF synchroniser, [2] is the edge-detect history bit.
    logic [2:0] upd_sync;
    logic [2:0] t1_sync;
    logic [2:0] t2_sync;
    logic       upd_p;
    logic       t1_p;
    logic       t2_p;

    // Synchronise the async AD9914 strobes into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            upd_sync <= '0;
            t1_sync  <= '0;
            t2_sync  <= '0;
        end else begin
            upd_sync <= {upd_sync[1:0], ad9914_update_2};
            t1_sync  <= {t1_sync[1:0], ad9914_trig_1};
            t2_sync  <= {t2_sync[1:0], ad9914_trig_2};
        end
    end

    // Rising-edge detect on the synchronised strobes.
    always_comb begin
        upd_p = upd_sync[1] & ~upd_sync[2];
        t1_p  = t1_sync[1] & ~t1_sync[2];
        t2_p  = t2_sync[1] & ~t2_sync[2];
    end

    // CT sequencing FSM with registered enable and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            ct_enable  <= 1'b0;
            ct_done    <= 1'b0;
            ct_timeout <= 1'b0;
            period_reg <= '0;
            cnt        <= '0;
            arm_cnt    <= '0;
`ifdef CT_REPEAT_EN
            rep_cnt    <= '0;
`endif
        end else begin
            ct_done    <= 1'b0;
            ct_timeout <= 1'b0;
            case (state)
                StIdle: begin
                    if (upd_p) begin
                        state      <= StArmed;
                        period_reg <= ct_period;
                        arm_cnt    <= '0;
                        ct_enable  <= 1'b1;
`ifdef CT_REPEAT_EN
                        rep_cnt    <= ct_repeat;
`endif
                    end
                end
                StArmed: begin
                    // Trigger beats a coincident update; period stays as armed.
                    if (t2_p) begin
                        state <= StRun;
                        cnt   <= '0;
                    end else if (upd_p) begin
                        period_reg <= ct_period;
                        arm_cnt    <= '0;
`ifdef CT_REPEAT_EN
                        rep_cnt    <= ct_repeat;
`endif
                    end else if ((ARM_TO != 0) && (arm_cnt == ARM_LAST)) begin
                        state      <= StIdle;
                        ct_enable  <= 1'b0;
                        ct_timeout <= 1'b1;
                    end else if (arm_cnt != '1) begin
                        arm_cnt <= arm_cnt + CNT_ONE;
                    end
                end
                StRun: begin
                    // Stops at period_reg, so the count never wraps even for all-ones.
                    if (cnt == period_reg) begin
                        state   <= StDone;
                        ct_done <= 1'b1;
`ifdef CT_REPEAT_EN
                        ct_enable <= (rep_cnt > 8'd1);
`else
                        ct_enable <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                StDone: begin
`ifdef CT_REPEAT_EN
                    if (rep_cnt > 8'd1) begin
                        rep_cnt   <= rep_cnt - 8'd1;
                        state     <= StArmed;
                        arm_cnt   <= '0;
                        ct_enable <= 1'b1;
                    end else begin
                        rep_cnt   <= '0;
                        state     <= StIdle;
                        ct_enable <= 1'b0;
                    end
`else
                    state     <= StIdle;
                    ct_enable <= 1'b0;
`endif
                end
                default: begin
                    state     <= StIdle;
                    ct_enable <= 1'b0;
                end
            endcase
        end
    end

    // Polarisation select; toggle modes continue from the current value.
    always_ff @(posedge clk) begin
        if (rst) begin
            tv <= 1'b1;
        end else begin
            unique case (tv_mode)
                2'b00: tv <= 1'b0;
                2'b01: tv <= 1'b1;
                2'b11: if (t1_p) tv <= ~tv;
                2'b10: if (ct_done) tv <= ~tv;
            endcase
        end
    end

    // Front-end switch outputs follow the registered CT enable.
    always_comb begin
        ad9914_osk_2 = ct_enable & ad9914_osk_temp;
        tr           = ct_enable;
        lo           = ct_enable;
        rx_ch_ctrl   = ct_enable ? RX_CT_VAL : rx_ch_pwr_ctrl;
        ct_busy      = ct_enable;
    end

endmodule

// File: tb/tb_ct_sequencer.sv
// Directed self-checking bench for ct_sequencer (ARM_TO shortened to 16).
module tb_ct_sequencer;

    localparam int unsigned CNT_W  = 32;
    localparam int unsigned RX_CH  = 3;
    localparam int unsigned ARM_TO = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] ct_period;
    logic [1:0]       tv_mode;
    logic             ad9914_update_2;
    logic             ad9914_trig_1;
    logic             ad9914_trig_2;
    logic             ad9914_osk_temp;
    logic [RX_CH-1:0] rx_ch_pwr_ctrl;
`ifdef CT_REPEAT_EN
    logic [7:0]       ct_repeat;
`endif
    logic             ad9914_osk_2;
    logic             tr;
    logic             lo;
    logic             tv;
    logic [RX_CH-1:0] rx_ch_ctrl;
    logic             ct_busy;
    logic             ct_done;
    logic             ct_timeout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ct_sequencer #(
        .CNT_W     (CNT_W),
        .RX_CH     (RX_CH),
        .ARM_TO    (ARM_TO),
        .RX_CT_VAL (3'b000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ct_period       (ct_period),
        .tv_mode         (tv_mode),
        .ad9914_update_2 (ad9914_update_2),
        .ad9914_trig_1   (ad9914_trig_1),
        .ad9914_trig_2   (ad9914_trig_2),
        .ad9914_osk_temp (ad9914_osk_temp),
        .rx_ch_pwr_ctrl  (rx_ch_pwr_ctrl),
`ifdef CT_REPEAT_EN
        .ct_repeat       (ct_repeat),
`endif
        .ad9914_osk_2    (ad9914_osk_2),
        .tr              (tr),
        .lo              (lo),
        .tv              (tv),
        .rx_ch_ctrl      (rx_ch_ctrl),
        .ct_busy         (ct_busy),
        .ct_done         (ct_done),
        .ct_timeout      (ct_timeout)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // which: 0 update, 1 trig_1, 2 trig_2, 3 update+trig_2. Held across one posedge.
    task automatic strobe(input int which);
        if (which == 0 || which == 3) ad9914_update_2 = 1'b1;
        if (which == 1) ad9914_trig_1 = 1'b1;
        if (which == 2 || which == 3) ad9914_trig_2 = 1'b1;
        tick(1);
        ad9914_update_2 = 1'b0;
        ad9914_trig_1   = 1'b0;
        ad9914_trig_2   = 1'b0;
    endtask

    // Arm, trigger, then count cycles from the internal t2_p cycle to ct_done (p+2 expected).
    task automatic run_ct(input logic [CNT_W-1:0] p, output int n);
        ct_period = p;
        strobe(0);
        tick(2);
        strobe(2);
        tick(1);
        n = 0;
        while (ct_done !== 1'b1 && n < 64) begin
            tick(1);
            n++;
        end
        if (ct_done !== 1'b1) n = -1;
    endtask

    task automatic test_reset;
        rst             = 1'b1;
        ct_period       = '0;
        tv_mode         = 2'b01;
        ad9914_update_2 = 1'b0;
        ad9914_trig_1   = 1'b0;
        ad9914_trig_2   = 1'b0;
        ad9914_osk_temp = 1'b1;
        rx_ch_pwr_ctrl  = 3'b101;
`ifdef CT_REPEAT_EN
        ct_repeat       = 8'd0;
`endif
        tick(3);
        checks++;
        if (ct_busy !== 1'b0 || tr !== 1'b0 || lo !== 1'b0) begin
            errors++;
            $display("FAIL reset_switches: busy/tr/lo=%b%b%b expected 000", ct_busy, tr, lo);
        end
        checks++;
        if (tv !== 1'b1) begin
            errors++;
            $display("FAIL reset_tv: got %b expected 1", tv);
        end
        checks++;
        if (ct_done !== 1'b0 || ct_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: done/timeout=%b%b expected 00", ct_done, ct_timeout);
        end
        checks++;
        if (rx_ch_ctrl !== 3'b101 || ad9914_osk_2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_rx_osk: rx=%b osk=%b expected 101 0", rx_ch_ctrl, ad9914_osk_2);
        end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_basic_window;
        int  n;
        logic busy_before;
        ct_period = 5;
        strobe(0);
        tick(1);
        checks++;
        if (ct_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_early: got %b expected 0", ct_busy);
        end
        tick(1);
        checks++;
        if (ct_busy !== 1'b1 || tr !== 1'b1 || lo !== 1'b1) begin
            errors++;
            $display("FAIL basic_armed: busy/tr/lo=%b%b%b expected 111", ct_busy, tr, lo);
        end
        checks++;
        if (rx_ch_ctrl !== 3'b000 || ad9914_osk_2 !== 1'b1) begin
            errors++;
            $display("FAIL basic_ct_outputs: rx=%b osk=%b expected 000 1", rx_ch_ctrl,
                     ad9914_osk_2);
        end
        ad9914_osk_temp = 1'b0;
        #1;
        checks++;
        if (ad9914_osk_2 !== 1'b0) begin
            errors++;
            $display("FAIL basic_osk_gate: got %b expected 0", ad9914_osk_2);
        end
        ad9914_osk_temp = 1'b1;
        strobe(2);
        tick(1);
        n = 0;
        busy_before = 1'b0;
        while (ct_done !== 1'b1 && n < 64) begin
            busy_before = ct_busy;
            tick(1);
            n++;
        end
        // Six RUN cycles, then ct_done in the following cycle.
        checks++;
        if (n != 7) begin
            errors++;
            $display("FAIL basic_window_len: got %0d expected 7", n);
        end
        checks++;
        if (busy_before !== 1'b1 || ct_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_edge: before/at done=%b%b expected 10", busy_before, ct_busy);
        end
        checks++;
        if (rx_ch_ctrl !== 3'b101 || tr !== 1'b0) begin
            errors++;
            $display("FAIL basic_restore: rx=%b tr=%b expected 101 0", rx_ch_ctrl, tr);
        end
        tick(1);
        checks++;
        if (ct_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: got %b expected 0", ct_done);
        end
    endtask

    task automatic test_period_zero;
        int n;
        run_ct(0, n);
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL period0_len: got %0d expected 2", n);
        end
        tick(1);
        checks++;
        if (ct_done !== 1'b0 || ct_busy !== 1'b0) begin
            errors++;
            $display("FAIL period0_after: done/busy=%b%b expected 00", ct_done, ct_busy);
        end
    endtask

    task automatic test_timeout;
        logic seen;
        ct_period = 4;
        strobe(0);
        tick(2);
        tick(15);
        checks++;
        if (ct_busy !== 1'b1 || ct_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: busy/to=%b%b expected 10", ct_busy, ct_timeout);
        end
        tick(1);
        checks++;
        if (ct_busy !== 1'b0 || ct_timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_fire: busy/to=%b%b expected 01", ct_busy, ct_timeout);
        end
        tick(1);
        checks++;
        if (ct_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: got %b expected 0", ct_timeout);
        end
        strobe(2);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (ct_done !== 1'b0 || ct_busy !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL timeout_late_trig: activity=%b expected 0", seen);
        end
    endtask

    task automatic test_back_to_back;
        int  n;
        logic seen;
        ct_period = 3;
        strobe(0);
        tick(2);
        ct_period = 9;
        strobe(3);
        tick(1);
        // Update edge that lands while RUN is active.
        ad9914_update_2 = 1'b1;
        n = 0;
        while (ct_done !== 1'b1 && n < 64) begin
            tick(1);
            n++;
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL coincide_period: got %0d expected 5", n);
        end
        ad9914_update_2 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (ct_busy !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL run_update_ignored: rearmed=%b expected 0", seen);
        end
    endtask

    task automatic test_tv;
        int   n;
        logic exp_tv;
        tv_mode = 2'b11;
        tick(1);
        exp_tv = 1'b1;
        checks++;
        if (tv !== exp_tv) begin
            errors++;
            $display("FAIL tv_mode11_start: got %b expected %b", tv, exp_tv);
        end
        for (int i = 0; i < 4; i++) begin
            strobe(1);
            tick(2);
            exp_tv = ~exp_tv;
            checks++;
            if (tv !== exp_tv) begin
                errors++;
                $display("FAIL tv_trig1_%0d: got %b expected %b", i, tv, exp_tv);
            end
        end
        tv_mode = 2'b10;
        for (int i = 0; i < 2; i++) begin
            run_ct(1, n);
            checks++;
            if (n != 3 || tv !== exp_tv) begin
                errors++;
                $display("FAIL tv_mode10_pre_%0d: len=%0d tv=%b expected 3 %b", i, n, tv, exp_tv);
            end
            tick(1);
            exp_tv = ~exp_tv;
            checks++;
            if (tv !== exp_tv) begin
                errors++;
                $display("FAIL tv_mode10_toggle_%0d: got %b expected %b", i, tv, exp_tv);
            end
        end
        tv_mode = 2'b00;
        tick(1);
        checks++;
        if (tv !== 1'b0) begin
            errors++;
            $display("FAIL tv_mode00: got %b expected 0", tv);
        end
        tv_mode = 2'b01;
        tick(1);
        checks++;
        if (tv !== 1'b1) begin
            errors++;
            $display("FAIL tv_mode01: got %b expected 1", tv);
        end
    endtask

    task automatic test_reset_mid_run;
        logic seen;
        tv_mode   = 2'b00;
        ct_period = 10;
        strobe(0);
        tick(2);
        strobe(2);
        tick(1);
        tick(3);
        checks++;
        if (ct_busy !== 1'b1 || tv !== 1'b0) begin
            errors++;
            $display("FAIL midrun_pre: busy/tv=%b%b expected 10", ct_busy, tv);
        end
        rst = 1'b1;
        tick(1);
        checks++;
        if (ct_busy !== 1'b0 || tv !== 1'b1 || tr !== 1'b0 || rx_ch_ctrl !== 3'b101) begin
            errors++;
            $display("FAIL midrun_reset: busy/tv/tr=%b%b%b rx=%b expected 010 101", ct_busy, tv,
                     tr, rx_ch_ctrl);
        end
        rst     = 1'b0;
        tv_mode = 2'b01;
        seen    = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (ct_done !== 1'b0 || ct_busy !== 1'b0) seen = 1'b1;
            tick(1);
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midrun_no_done: activity=%b expected 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_basic_window();
        test_period_zero();
        test_timeout();
        test_back_to_back();
        test_tv();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
